mips_sc_org: RTL and testbench
==============================

MIPS_SC_ORG -- requirements
Module: mips_sc_org

Interface
REQ-001 SHALL declare parameter IMEM_WORDS, default 64, meaning instruction-memory depth in 32-bit words.
REQ-002 SHALL declare parameter DMEM_WORDS, default 64, meaning data-memory depth in 32-bit words.
REQ-003 SHALL declare port clk, input, 1 bit: system clock; all state updates on its rising edge.
REQ-004 SHALL declare port reset, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL declare port writedata, output, 32 bits: register rt value presented to data memory (store data).
REQ-006 SHALL declare port dataadr, output, 32 bits: ALU result used as data-memory byte address.
REQ-007 SHALL declare port memwrite, output, 1 bit: data-memory write enable for the current instruction.
REQ-008 SHALL expose hierarchical names for bench access: top-level signal pc [31:0]; instance imem with array RAM [0:IMEM_WORDS-1] of 32 bits; instance dmem with array RAM [0:DMEM_WORDS-1] of 32 bits; instance cpu containing instance dp containing instance rf with array rf [0:31] of 32 bits.

Function
REQ-009 SHALL execute one instruction per clk cycle (single-cycle MIPS-32, no pipeline, no stalls).
REQ-010 SHALL read imem combinationally at word index pc[31:2]; pc[1:0] ignored.
REQ-011 SHALL support R-type add, sub, and, or, slt (opcode 0x00, funct 0x20/0x22/0x24/0x25/0x2A), lw (0x23), sw (0x2B), beq (0x04), addi (0x08), j (0x02).
REQ-012 SHALL treat unsupported opcodes/functs as no-ops: no register write, no memory write, pc advances by 4.
REQ-013 SHALL sign-extend 16-bit immediates for addi/lw/sw/beq; arithmetic is 32-bit two's-complement, overflow ignored (wraps, no trap).
REQ-014 SHALL compute slt as signed compare, result 1 or 0.
REQ-015 SHALL update pc each rising edge: beq taken -> pc+4+(signext(imm)<<2); j -> {pc+4[31:28], addr26, 2'b00}; otherwise pc+4.
REQ-016 SHALL make a beq/j to its own address hold pc constant (halt idiom).
REQ-017 SHALL provide a 32x32 register file: two combinational read ports, one write port on rising edge; register 0 reads 0 always and writes to it are discarded.
REQ-018 SHALL write rd for R-type and rt for addi/lw; lw writes dmem word at dataadr[31:2].
REQ-019 SHALL write writedata into dmem.RAM[dataadr[31:2]] on the rising edge when memwrite=1; dmem reads combinational.
REQ-020 SHALL index imem/dmem modulo their depth (upper address bits ignored); no fault on out-of-range access.
REQ-021 SHALL drive memwrite=1 only for sw, and only while reset is high.
REQ-022 SHALL NOT initialise imem/dmem contents internally; contents are loaded externally at time zero.

Reset
REQ-023 SHALL set pc to 0x00000000 on a rising edge with reset=0.
REQ-024 SHALL suppress register-file and dmem writes on any edge with reset=0.
REQ-025 SHALL leave register-file, imem and dmem contents unchanged by reset; reset mid-program restarts from pc=0 with state retained.
REQ-026 SHALL fetch the instruction at address 0x0 on the first edge after reset deasserts.

Structure
REQ-027 SHALL place opcode, funct and ALU-control encodings in shared package mips_pkg.
REQ-028 SHALL use sub-modules: cpu (core), containing controller and datapath dp, where dp contains regfile rf; plus imem and dmem memories.

Verification
REQ-029 SHALL verify: program addi $t0,$0,999; sw $t0,0($0); j 0x08 (halt), dmem[0]=0 -> pc reaches 0x08, $t0 (rf[8])=999, dmem.RAM[0]=999, memwrite=1 only during the sw cycle.
REQ-030 SHALL verify: addi $t1,$0,-5; addi $t2,$0,3; slt $t3,$t1,$t2; sub $t4,$t2,$t1 -> rf[11]=1, rf[12]=8.
REQ-031 SHALL verify: lw $t0,4($0) with dmem[1]=0x12345678; beq $t0,$t0,+1 skips next instruction -> rf[8]=0x12345678, skipped instruction has no effect.
REQ-032 SHALL verify: addi $0,$0,7 -> rf[0] reads 0.
REQ-033 SHALL verify: reset=0 asserted mid-program after $t0 written -> pc=0 next edge, memwrite=0 during reset, rf[8] retained.

Source files
------------

// File: rtl/mips_pkg.sv
// ============================================================================
// Module   : mips_pkg
// Purpose  : Shared opcode/funct/ALU encodings and control bundle for the
//            single-cycle MIPS core.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_ctrl_e;

  typedef struct packed {
    logic      regwrite;
    logic      regdst;
    logic      alusrc;
    logic      branch;
    logic      memwrite;
    logic      memtoreg;
    logic      jump;
    alu_ctrl_e alu;
  } ctrl_t;

  function automatic logic [31:0] alu_eval(input alu_ctrl_e op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    case (op)
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_SUB: return a - b;
      ALU_SLT: return {31'd0, ($signed(a) < $signed(b))};
      default: return a + b;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mips_sc_org_cpu.sv
// ============================================================================
// Module   : mips_regfile / mips_controller / mips_datapath / mips_cpu
// Purpose  : Single-cycle MIPS core: decode, register file, ALU and PC logic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_regfile (
  input  logic        clk_i,
  input  logic        we_i,
  input  logic [4:0]  ra1_i,
  input  logic [4:0]  ra2_i,
  input  logic [4:0]  wa_i,
  input  logic [31:0] wd_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o
);

  logic [31:0] rf [0:31];

  always_ff @(posedge clk_i) begin
    rf[0] <= '0;
    if (we_i && (wa_i != 5'd0)) begin
      rf[wa_i] <= wd_i;
    end
  end

  assign rd1_o = (ra1_i == 5'd0) ? '0 : rf[ra1_i];
  assign rd2_o = (ra2_i == 5'd0) ? '0 : rf[ra2_i];

endmodule

module mips_controller
  import mips_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  input  logic       reset_n_i,
  output ctrl_t      ctrl_o
);

  ctrl_t c;

  always_comb begin
    c     = '0;
    c.alu = ALU_ADD;
    case (op_i)
      OP_RTYPE: begin
        c.regdst = 1'b1;
        case (funct_i)
          FN_ADD: begin c.regwrite = 1'b1; c.alu = ALU_ADD; end
          FN_SUB: begin c.regwrite = 1'b1; c.alu = ALU_SUB; end
          FN_AND: begin c.regwrite = 1'b1; c.alu = ALU_AND; end
          FN_OR:  begin c.regwrite = 1'b1; c.alu = ALU_OR;  end
          FN_SLT: begin c.regwrite = 1'b1; c.alu = ALU_SLT; end
          default: ;
        endcase
      end
      OP_LW:   begin c.regwrite = 1'b1; c.alusrc = 1'b1; c.memtoreg = 1'b1; end
      OP_SW:   begin c.alusrc = 1'b1; c.memwrite = 1'b1; end
      OP_BEQ:  begin c.branch = 1'b1; c.alu = ALU_SUB; end
      OP_ADDI: begin c.regwrite = 1'b1; c.alusrc = 1'b1; end
      OP_J:    c.jump = 1'b1;
      default: ;
    endcase
    // Architectural writes are blocked for the whole reset window.
    c.regwrite = c.regwrite & reset_n_i;
    c.memwrite = c.memwrite & reset_n_i;
  end

  assign ctrl_o = c;

endmodule

module mips_datapath
  import mips_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic [25:0] instr_i,
  input  logic        regwrite_i,
  input  logic        regdst_i,
  input  logic        alusrc_i,
  input  logic        branch_i,
  input  logic        memtoreg_i,
  input  logic        jump_i,
  input  alu_ctrl_e   alu_i,
  input  logic [31:0] readdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] aluout_o,
  output logic [31:0] writedata_o
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] w_signimm, w_pcplus4, w_pcbranch;
  logic [31:0] w_srca, w_rd2, w_srcb, w_alu, w_wd;
  logic [4:0]  w_wa;

  assign w_signimm  = {{16{instr_i[15]}}, instr_i[15:0]};
  assign w_pcplus4  = pc_q + 32'd4;
  assign w_pcbranch = w_pcplus4 + {w_signimm[29:0], 2'b00};

  mips_regfile rf (
    .clk_i (clk_i),
    .we_i  (regwrite_i),
    .ra1_i (instr_i[25:21]),
    .ra2_i (instr_i[20:16]),
    .wa_i  (w_wa),
    .wd_i  (w_wd),
    .rd1_o (w_srca),
    .rd2_o (w_rd2)
  );

  assign w_srcb = alusrc_i ? w_signimm : w_rd2;
  assign w_alu  = alu_eval(alu_i, w_srca, w_srcb);
  assign w_wa   = regdst_i ? instr_i[15:11] : instr_i[20:16];
  assign w_wd   = memtoreg_i ? readdata_i : w_alu;

  always_comb begin
    pc_d = w_pcplus4;
    if (jump_i) begin
      pc_d = {w_pcplus4[31:28], instr_i[25:0], 2'b00};
    end else if (branch_i && (w_alu == 32'd0)) begin
      pc_d = w_pcbranch;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o        = pc_q;
  assign aluout_o    = w_alu;
  assign writedata_o = w_rd2;

endmodule

module mips_cpu
  import mips_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] readdata_i,
  output logic [31:0] pc_o,
  output logic        memwrite_o,
  output logic [31:0] aluout_o,
  output logic [31:0] writedata_o
);

  ctrl_t w_ctrl;

  mips_controller ctrl (
    .op_i      (instr_i[31:26]),
    .funct_i   (instr_i[5:0]),
    .reset_n_i (reset_n_i),
    .ctrl_o    (w_ctrl)
  );

  mips_datapath dp (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .instr_i     (instr_i[25:0]),
    .regwrite_i  (w_ctrl.regwrite),
    .regdst_i    (w_ctrl.regdst),
    .alusrc_i    (w_ctrl.alusrc),
    .branch_i    (w_ctrl.branch),
    .memtoreg_i  (w_ctrl.memtoreg),
    .jump_i      (w_ctrl.jump),
    .alu_i       (w_ctrl.alu),
    .readdata_i  (readdata_i),
    .pc_o        (pc_o),
    .aluout_o    (aluout_o),
    .writedata_o (writedata_o)
  );

  assign memwrite_o = w_ctrl.memwrite;

endmodule

`default_nettype wire

// File: rtl/mips_sc_org_mem.sv
// ============================================================================
// Module   : mips_ram
// Purpose  : Word memory, combinational read, clocked write; byte address is
//            reduced modulo DEPTH words.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_ram #(
  parameter int DEPTH = 64
) (
  input  logic        clk_i,
  input  logic        we_i,
  input  logic [31:0] adr_i,
  input  logic [31:0] wd_i,
  output logic [31:0] rd_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]   RAM [0:DEPTH-1];
  logic [AW-1:0] w_idx;

  // Word index wraps on depth so any address is legal.
  assign w_idx = AW'((adr_i >> 2) % 32'(DEPTH));
  assign rd_o  = RAM[w_idx];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      RAM[w_idx] <= wd_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mips_sc_org.sv
// ============================================================================
// Module   : mips_sc_org
// Purpose  : Single-cycle MIPS system: core plus instruction and data memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_sc_org #(
  parameter int IMEM_WORDS = 64,
  parameter int DMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] writedata,
  output logic [31:0] dataadr,
  output logic        memwrite
);

  logic [31:0] pc;
  logic [31:0] instr;
  logic [31:0] readdata;

  mips_cpu cpu (
    .clk_i       (clk),
    .reset_n_i   (reset),
    .instr_i     (instr),
    .readdata_i  (readdata),
    .pc_o        (pc),
    .memwrite_o  (memwrite),
    .aluout_o    (dataadr),
    .writedata_o (writedata)
  );

  // Program image is loaded from outside; the write port stays idle.
  mips_ram #(.DEPTH(IMEM_WORDS)) imem (
    .clk_i (clk),
    .we_i  (1'b0),
    .adr_i (pc),
    .wd_i  (32'd0),
    .rd_o  (instr)
  );

  mips_ram #(.DEPTH(DMEM_WORDS)) dmem (
    .clk_i (clk),
    .we_i  (memwrite),
    .adr_i (dataadr),
    .wd_i  (writedata),
    .rd_o  (readdata)
  );

endmodule

`default_nettype wire

// File: tb/tb_mips_sc_org.sv
// ============================================================================
// Module   : tb_mips_sc_org
// Purpose  : Directed self-checking bench for the single-cycle MIPS system.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_sc_org;

  logic        clk;
  logic        reset;
  logic [31:0] writedata;
  logic [31:0] dataadr;
  logic        memwrite;

  int n_cmp = 0;
  int n_err = 0;

  mips_sc_org #(.IMEM_WORDS(64), .DMEM_WORDS(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .writedata (writedata),
    .dataadr   (dataadr),
    .memwrite  (memwrite)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 64; i++) dut.imem.RAM[i] <= 32'h0;
  endtask

  task automatic set_imem(input int idx, input logic [31:0] w);
    dut.imem.RAM[idx] <= w;
  endtask

  // Hold reset across one edge with the new image loaded, then release.
  task automatic restart();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear_imem();
    set_imem(0, 32'hAC080010);            // sw $t0,0x10($0)
    dut.dmem.RAM[4] <= 32'h0000CAFE;
    tick();
    tick();
    n_cmp++; if (dut.pc !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want %h", dut.pc, 32'h0); end
    n_cmp++; if (memwrite !== 1'b0) begin n_err++; $display("FAIL reset_memwrite: got %b want 0", memwrite); end
    tick();
    n_cmp++; if (dut.dmem.RAM[4] !== 32'h0000CAFE) begin n_err++; $display("FAIL reset_dmem_hold: got %h want %h", dut.dmem.RAM[4], 32'h0000CAFE); end
  endtask

  task automatic test_store_halt();
    reset = 1'b0;
    clear_imem();
    set_imem(0, 32'h200803E7);            // addi $t0,$0,999
    set_imem(1, 32'hAC080000);            // sw $t0,0($0)
    set_imem(2, 32'h08000002);            // j 0x08
    dut.dmem.RAM[0] <= 32'h0;
    restart();
    n_cmp++; if (memwrite !== 1'b0) begin n_err++; $display("FAIL sh_memwrite_c0: got %b want 0", memwrite); end
    tick();
    n_cmp++; if (dut.pc !== 32'h4) begin n_err++; $display("FAIL sh_pc_c1: got %h want %h", dut.pc, 32'h4); end
    n_cmp++; if (dut.cpu.dp.rf.rf[8] !== 32'd999) begin n_err++; $display("FAIL sh_t0: got %h want %h", dut.cpu.dp.rf.rf[8], 32'd999); end
    n_cmp++; if (memwrite !== 1'b1) begin n_err++; $display("FAIL sh_memwrite_sw: got %b want 1", memwrite); end
    n_cmp++; if (writedata !== 32'd999) begin n_err++; $display("FAIL sh_writedata: got %h want %h", writedata, 32'd999); end
    n_cmp++; if (dataadr !== 32'd0) begin n_err++; $display("FAIL sh_dataadr: got %h want %h", dataadr, 32'd0); end
    tick();
    n_cmp++; if (dut.pc !== 32'h8) begin n_err++; $display("FAIL sh_pc_c2: got %h want %h", dut.pc, 32'h8); end
    n_cmp++; if (dut.dmem.RAM[0] !== 32'd999) begin n_err++; $display("FAIL sh_dmem0: got %h want %h", dut.dmem.RAM[0], 32'd999); end
    n_cmp++; if (memwrite !== 1'b0) begin n_err++; $display("FAIL sh_memwrite_j: got %b want 0", memwrite); end
    tick();
    tick();
    n_cmp++; if (dut.pc !== 32'h8) begin n_err++; $display("FAIL sh_pc_halt: got %h want %h", dut.pc, 32'h8); end
  endtask

  task automatic test_alu();
    reset = 1'b0;
    clear_imem();
    set_imem(0,  32'h2009FFFB);           // addi $t1,$0,-5
    set_imem(1,  32'h200A0003);           // addi $t2,$0,3
    set_imem(2,  32'h012A582A);           // slt  $t3,$t1,$t2
    set_imem(3,  32'h01496022);           // sub  $t4,$t2,$t1
    set_imem(4,  32'h012A6824);           // and  $t5,$t1,$t2
    set_imem(5,  32'h012A7025);           // or   $t6,$t1,$t2
    set_imem(6,  32'h012A7820);           // add  $t7,$t1,$t2
    set_imem(7,  32'h012A8026);           // xor  $s0 (unsupported funct)
    set_imem(8,  32'h34111234);           // ori  $s1 (unsupported opcode)
    set_imem(9,  32'h0149902A);           // slt  $s2,$t2,$t1
    set_imem(10, 32'h0800000A);           // j 0x28
    dut.cpu.dp.rf.rf[16] <= 32'hA5A5A5A5;
    dut.cpu.dp.rf.rf[17] <= 32'h0;
    dut.cpu.dp.rf.rf[18] <= 32'hFFFFFFFF;
    restart();
    for (int i = 0; i < 11; i++) tick();
    n_cmp++; if (dut.cpu.dp.rf.rf[9] !== 32'hFFFFFFFB) begin n_err++; $display("FAIL alu_addi_neg: got %h want %h", dut.cpu.dp.rf.rf[9], 32'hFFFFFFFB); end
    n_cmp++; if (dut.cpu.dp.rf.rf[11] !== 32'h1) begin n_err++; $display("FAIL alu_slt_true: got %h want %h", dut.cpu.dp.rf.rf[11], 32'h1); end
    n_cmp++; if (dut.cpu.dp.rf.rf[12] !== 32'h8) begin n_err++; $display("FAIL alu_sub: got %h want %h", dut.cpu.dp.rf.rf[12], 32'h8); end
    n_cmp++; if (dut.cpu.dp.rf.rf[13] !== 32'h3) begin n_err++; $display("FAIL alu_and: got %h want %h", dut.cpu.dp.rf.rf[13], 32'h3); end
    n_cmp++; if (dut.cpu.dp.rf.rf[14] !== 32'hFFFFFFFB) begin n_err++; $display("FAIL alu_or: got %h want %h", dut.cpu.dp.rf.rf[14], 32'hFFFFFFFB); end
    n_cmp++; if (dut.cpu.dp.rf.rf[15] !== 32'hFFFFFFFE) begin n_err++; $display("FAIL alu_add: got %h want %h", dut.cpu.dp.rf.rf[15], 32'hFFFFFFFE); end
    n_cmp++; if (dut.cpu.dp.rf.rf[16] !== 32'hA5A5A5A5) begin n_err++; $display("FAIL alu_bad_funct: got %h want %h", dut.cpu.dp.rf.rf[16], 32'hA5A5A5A5); end
    n_cmp++; if (dut.cpu.dp.rf.rf[17] !== 32'h0) begin n_err++; $display("FAIL alu_bad_op: got %h want %h", dut.cpu.dp.rf.rf[17], 32'h0); end
    n_cmp++; if (dut.cpu.dp.rf.rf[18] !== 32'h0) begin n_err++; $display("FAIL alu_slt_false: got %h want %h", dut.cpu.dp.rf.rf[18], 32'h0); end
    n_cmp++; if (dut.pc !== 32'h28) begin n_err++; $display("FAIL alu_pc_halt: got %h want %h", dut.pc, 32'h28); end
  endtask

  task automatic test_load_branch();
    reset = 1'b0;
    clear_imem();
    set_imem(0, 32'h8C080004);            // lw  $t0,4($0)
    set_imem(1, 32'h11080001);            // beq $t0,$t0,+1
    set_imem(2, 32'h200D0037);            // addi $t5,$0,55 (skipped)
    set_imem(3, 32'h20000007);            // addi $0,$0,7
    set_imem(4, 32'hAC000008);            // sw  $0,8($0)
    set_imem(5, 32'h10080005);            // beq $0,$t0,+5 (not taken)
    set_imem(6, 32'h8C0E0104);            // lw  $t6,0x104($0) wraps to word 1
    set_imem(7, 32'h1000FFFF);            // beq $0,$0,-1
    dut.dmem.RAM[1] <= 32'h12345678;
    dut.dmem.RAM[2] <= 32'hDEADBEEF;
    dut.cpu.dp.rf.rf[13] <= 32'h13;
    dut.cpu.dp.rf.rf[14] <= 32'h0;
    restart();
    tick();
    n_cmp++; if (dut.cpu.dp.rf.rf[8] !== 32'h12345678) begin n_err++; $display("FAIL lb_lw: got %h want %h", dut.cpu.dp.rf.rf[8], 32'h12345678); end
    tick();
    n_cmp++; if (dut.pc !== 32'hC) begin n_err++; $display("FAIL lb_beq_taken_pc: got %h want %h", dut.pc, 32'hC); end
    tick();
    n_cmp++; if (memwrite !== 1'b1 || dataadr !== 32'h8 || writedata !== 32'h0) begin
      n_err++; $display("FAIL lb_sw_zero: got we=%b adr=%h wd=%h want we=1 adr=8 wd=0", memwrite, dataadr, writedata);
    end
    for (int i = 0; i < 4; i++) tick();
    n_cmp++; if (dut.pc !== 32'h1C) begin n_err++; $display("FAIL lb_pc_halt: got %h want %h", dut.pc, 32'h1C); end
    n_cmp++; if (dut.cpu.dp.rf.rf[13] !== 32'h13) begin n_err++; $display("FAIL lb_skipped: got %h want %h", dut.cpu.dp.rf.rf[13], 32'h13); end
    n_cmp++; if (dut.cpu.dp.rf.rf[0] !== 32'h0) begin n_err++; $display("FAIL lb_r0: got %h want %h", dut.cpu.dp.rf.rf[0], 32'h0); end
    n_cmp++; if (dut.dmem.RAM[2] !== 32'h0) begin n_err++; $display("FAIL lb_r0_store: got %h want %h", dut.dmem.RAM[2], 32'h0); end
    n_cmp++; if (dut.cpu.dp.rf.rf[14] !== 32'h12345678) begin n_err++; $display("FAIL lb_dmem_wrap: got %h want %h", dut.cpu.dp.rf.rf[14], 32'h12345678); end
  endtask

  task automatic test_reset_mid();
    reset = 1'b0;
    clear_imem();
    set_imem(0, 32'h20080077);            // addi $t0,$0,0x77
    set_imem(1, 32'hAC080010);            // sw   $t0,0x10($0)
    set_imem(2, 32'h08000002);            // j 0x08
    dut.dmem.RAM[4] <= 32'h0;
    restart();
    tick();
    n_cmp++; if (memwrite !== 1'b1) begin n_err++; $display("FAIL rm_sw_before: got %b want 1", memwrite); end
    reset = 1'b0;
    set_imem(0, 32'h20080099);            // addi $t0,$0,0x99
    #1;
    n_cmp++; if (memwrite !== 1'b0) begin n_err++; $display("FAIL rm_memwrite_gated: got %b want 0", memwrite); end
    tick();
    n_cmp++; if (dut.pc !== 32'h0) begin n_err++; $display("FAIL rm_pc: got %h want %h", dut.pc, 32'h0); end
    n_cmp++; if (dut.dmem.RAM[4] !== 32'h0) begin n_err++; $display("FAIL rm_dmem: got %h want %h", dut.dmem.RAM[4], 32'h0); end
    tick();
    n_cmp++; if (dut.cpu.dp.rf.rf[8] !== 32'h77) begin n_err++; $display("FAIL rm_rf_retained: got %h want %h", dut.cpu.dp.rf.rf[8], 32'h77); end
    reset = 1'b1;
    tick();
    n_cmp++; if (dut.cpu.dp.rf.rf[8] !== 32'h99 || dut.pc !== 32'h4) begin
      n_err++; $display("FAIL rm_restart: got t0=%h pc=%h want t0=99 pc=4", dut.cpu.dp.rf.rf[8], dut.pc);
    end
  endtask

  initial begin
    reset = 1'b0;
    test_reset();
    test_store_halt();
    test_alu();
    test_load_branch();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
